// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped write-through, no-write-allocate cache with refill FSM and hit/miss counters
module dm_cache_ctrl #(
    parameter int RISC_data      = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int LINES          = 32,
    parameter int ADDR_W         = 12,
    parameter int CNT_W          = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                MemRead,
    input  logic                                MemWrite,
    input  logic [ADDR_W-1:0]                   A,
    input  logic [RISC_data-1:0]                WD_RISC,
    output logic [RISC_data-1:0]                RD_RISC,
    output logic                                stall,
    output logic                                main_rd_req,
    output logic                                main_wr_req,
    output logic [ADDR_W-1:0]                   main_addr,
    output logic [RISC_data-1:0]                main_WD,
    input  logic [RISC_data*WORDS_PER_LINE-1:0] main_RD,
    input  logic                                main_ready,
    output logic [CNT_W-1:0]                    hit_cnt,
    output logic [CNT_W-1:0]                    miss_cnt
);
    localparam int MAIN_W = RISC_data * WORDS_PER_LINE;
    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {IDLE, REFILL, WTHRU} state_t;

    state_t              r_state, w_state_nx;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [MAIN_W-1:0]   r_data [LINES];
    logic [OFF_W-1:0]    w_off;
    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit, w_fill, w_wupd, w_req;
    logic [RISC_data-1:0] w_word, w_line_word, w_wd_nx;
    logic                w_rd_req_nx, w_wr_req_nx;
    logic [ADDR_W-1:0]   w_addr_nx;

    assign w_off       = A[OFF_W-1:0];
    assign w_idx       = A[OFF_W +: IDX_W];
    assign w_tag       = A[ADDR_W-1 -: TAG_W];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_word      = r_data[w_idx][w_off*RISC_data +: RISC_data];
    assign w_line_word = main_RD[w_off*RISC_data +: RISC_data];
    assign w_req       = (r_state == IDLE) && (MemRead || MemWrite);

    always_comb begin
        w_state_nx  = r_state;
        stall       = 1'b0;
        RD_RISC     = '0;
        w_fill      = 1'b0;
        w_wupd      = 1'b0;
        w_rd_req_nx = main_rd_req;
        w_wr_req_nx = main_wr_req;
        w_addr_nx   = main_addr;
        w_wd_nx     = main_WD;
        case (r_state)
            IDLE: begin
                if (MemWrite) begin
                    stall       = 1'b1;
                    w_state_nx  = WTHRU;
                    w_wr_req_nx = 1'b1;
                    w_addr_nx   = A;
                    w_wd_nx     = WD_RISC;
                end else if (MemRead && w_hit) begin
                    RD_RISC = w_word;
                end else if (MemRead) begin
                    stall       = 1'b1;
                    w_state_nx  = REFILL;
                    w_rd_req_nx = 1'b1;
                    w_addr_nx   = {A[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                end
            end
            REFILL: begin
                stall = !main_ready;
                if (main_ready) begin
                    RD_RISC     = w_line_word;
                    w_fill      = 1'b1;
                    w_state_nx  = IDLE;
                    w_rd_req_nx = 1'b0;
                end
            end
            WTHRU: begin
                stall = !main_ready;
                if (main_ready) begin
                    w_wupd      = w_hit;
                    w_state_nx  = IDLE;
                    w_wr_req_nx = 1'b0;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            main_rd_req <= 1'b0;
            main_wr_req <= 1'b0;
            main_addr   <= '0;
            main_WD     <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
        end else begin
            r_state     <= w_state_nx;
            main_rd_req <= w_rd_req_nx;
            main_wr_req <= w_wr_req_nx;
            main_addr   <= w_addr_nx;
            main_WD     <= w_wd_nx;
            if (w_fill) r_valid[w_idx] <= 1'b1;
            if (w_req && w_hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            if (w_req && !w_hit && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
        end
    end

    // Line storage is not reset; validity alone governs hits.
    always_ff @(posedge clk) begin
        if (!rst && w_fill) begin
            r_data[w_idx] <= main_RD;
            r_tag[w_idx]  <= w_tag;
        end else if (!rst && w_wupd) begin
            r_data[w_idx][w_off*RISC_data +: RISC_data] <= WD_RISC;
        end
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: table-driven cycle vectors plus a counter saturation sequence
module tb_dm_cache_ctrl;
    logic         clk = 1'b0;
    logic         rst, MemRead, MemWrite, main_ready;
    logic [11:0]  A;
    logic [31:0]  WD_RISC, RD_RISC, main_WD;
    logic         stall, main_rd_req, main_wr_req;
    logic [11:0]  main_addr;
    logic [127:0] main_RD;
    logic [3:0]   hit_cnt, miss_cnt;

    int n_chk = 0;
    int n_err = 0;
    int row   = 0;

    localparam logic [127:0] L1  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] L1B = 128'h44444444_33333333_DEADBEEF_11111111;
    localparam logic [127:0] L2  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [31:0]  DB  = 32'hDEADBEEF;

    dm_cache_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .A(A),
        .WD_RISC(WD_RISC), .RD_RISC(RD_RISC), .stall(stall),
        .main_rd_req(main_rd_req), .main_wr_req(main_wr_req),
        .main_addr(main_addr), .main_WD(main_WD), .main_RD(main_RD),
        .main_ready(main_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         r, rd, wr;
        logic [11:0]  a;
        logic [31:0]  wd;
        logic         rdy;
        logic [127:0] ln;
        logic         s, crd;
        logic [31:0]  rdd;
        logic         rq, wq;
        logic [11:0]  ma;
        logic [31:0]  mw;
        int           hc, mc;
    } vec_t;

    vec_t q[$];

    function automatic vec_t mk(input logic r, rd, wr, input logic [11:0] a, input logic [31:0] wd,
                                input logic rdy, input logic [127:0] ln, input logic s, crd,
                                input logic [31:0] rdd, input logic rq, wq, input logic [11:0] ma,
                                input logic [31:0] mw, input int hc, mc);
        vec_t v;
        v.r = r; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.rdy = rdy; v.ln = ln;
        v.s = s; v.crd = crd; v.rdd = rdd; v.rq = rq; v.wq = wq; v.ma = ma; v.mw = mw;
        v.hc = hc; v.mc = mc;
        return v;
    endfunction

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %0h expected %0h", n, row, act, exp);
        end
    endtask

    initial begin
        // r rd wr  a  wd  rdy line | s crd rdd | rq wq ma mw | hc mc
        q.push_back(mk(0,0,0,12'h000,0,0,0,           0,1,0,              0,0,0,0,              0,0));
        q.push_back(mk(0,1,0,12'h005,0,0,0,           1,0,0,              0,0,0,0,              0,0));
        q.push_back(mk(0,1,0,12'h005,0,0,0,           1,0,0,              1,0,12'h004,0,        0,1));
        q.push_back(mk(0,1,0,12'h005,0,0,0,           1,0,0,              1,0,12'h004,0,        0,1));
        q.push_back(mk(0,1,0,12'h005,0,1,L1,          0,1,32'h22222222,   1,0,12'h004,0,        0,1));
        q.push_back(mk(0,1,0,12'h006,0,0,0,           0,1,32'h33333333,   0,0,0,0,              0,1));
        q.push_back(mk(0,0,1,12'h005,DB,0,0,          1,0,0,              0,0,0,0,              1,1));
        q.push_back(mk(0,0,1,12'h005,DB,0,0,          1,0,0,              0,1,12'h005,DB,       2,1));
        q.push_back(mk(0,0,1,12'h005,DB,1,0,          0,0,0,              0,1,12'h005,DB,       2,1));
        q.push_back(mk(0,1,0,12'h005,0,0,0,           0,1,DB,             0,0,0,0,              2,1));
        q.push_back(mk(0,1,0,12'h004,0,0,0,           0,1,32'h11111111,   0,0,0,0,              3,1));
        q.push_back(mk(0,0,1,12'h085,32'h12345678,0,0,1,0,0,              0,0,0,0,              4,1));
        q.push_back(mk(0,0,1,12'h085,32'h12345678,1,0,0,0,0,              0,1,12'h085,32'h12345678,4,2));
        q.push_back(mk(0,1,0,12'h005,0,0,0,           0,1,DB,             0,0,0,0,              4,2));
        q.push_back(mk(0,1,0,12'h085,0,0,0,           1,0,0,              0,0,0,0,              5,2));
        q.push_back(mk(0,1,0,12'h085,0,1,L2,          0,1,32'hBBBBBBBB,   1,0,12'h084,0,        5,3));
        q.push_back(mk(0,1,0,12'h005,0,0,0,           1,0,0,              0,0,0,0,              5,3));
        q.push_back(mk(0,1,0,12'h005,0,0,0,           1,0,0,              1,0,12'h004,0,        5,4));
        q.push_back(mk(0,1,0,12'h005,0,1,L1B,         0,1,DB,             1,0,12'h004,0,        5,4));
        q.push_back(mk(0,0,0,12'h000,0,1,0,           0,1,0,              0,0,0,0,              5,4));
        q.push_back(mk(0,1,0,12'h006,0,0,0,           0,1,32'h33333333,   0,0,0,0,              5,4));
        q.push_back(mk(0,1,1,12'h004,32'h0BADF00D,0,0,1,0,0,              0,0,0,0,              6,4));
        q.push_back(mk(0,1,1,12'h004,32'h0BADF00D,1,0,0,0,0,              0,1,12'h004,32'h0BADF00D,7,4));
        q.push_back(mk(0,1,0,12'h004,0,0,0,           0,1,32'h0BADF00D,   0,0,0,0,              7,4));
        q.push_back(mk(0,1,0,12'h00A,0,0,0,           1,0,0,              0,0,0,0,              8,4));
        q.push_back(mk(1,1,0,12'h00A,0,0,0,           1,0,0,              1,0,12'h008,0,        8,5));
        q.push_back(mk(0,0,0,12'h000,0,0,0,           0,1,0,              0,0,0,0,              0,0));
        q.push_back(mk(0,1,0,12'h005,0,0,0,           1,0,0,              0,0,0,0,              0,0));
        q.push_back(mk(0,1,0,12'h005,0,1,L1B,         0,1,DB,             1,0,12'h004,0,        0,1));

        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; A = '0; WD_RISC = '0;
        main_ready = 1'b0; main_RD = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_main_addr", main_addr, 0);
        chk("reset_main_WD", main_WD, 0);

        foreach (q[i]) begin
            @(negedge clk);
            row = i;
            rst = q[i].r; MemRead = q[i].rd; MemWrite = q[i].wr; A = q[i].a;
            WD_RISC = q[i].wd; main_ready = q[i].rdy; main_RD = q[i].ln;
            #1;
            chk("stall", stall, q[i].s);
            chk("main_rd_req", main_rd_req, q[i].rq);
            chk("main_wr_req", main_wr_req, q[i].wq);
            chk("hit_cnt", hit_cnt, 128'(q[i].hc));
            chk("miss_cnt", miss_cnt, 128'(q[i].mc));
            if (q[i].crd) chk("RD_RISC", RD_RISC, q[i].rdd);
            if (q[i].rq || q[i].wq) chk("main_addr", main_addr, q[i].ma);
            if (q[i].wq) chk("main_WD", main_WD, q[i].mw);
        end

        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            row = 100 + j;
            rst = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; A = 12'h006; main_ready = 1'b0; main_RD = '0;
            #1;
            chk("sat_stall", stall, 0);
            chk("sat_RD_RISC", RD_RISC, 32'h33333333);
            chk("sat_hit_cnt", hit_cnt, 128'((j > 15) ? 15 : j));
        end
        @(negedge clk);
        row = 200;
        MemRead = 1'b0;
        #1;
        chk("sat_hit_cnt_final", hit_cnt, 15);
        chk("sat_miss_cnt_final", miss_cnt, 1);
        chk("idle_RD_RISC", RD_RISC, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
